fos_tdm_iir: RTL and testbench
==============================

# fos_tdm_iir

Time-multiplexed, parametrised first-order IIR section (transposed form) serving `NCH` independent channels with one shared iterative radix-4 Booth multiplier. Per-channel coefficient and state registers, valid/ready streaming on input and output, and a programmable fixed-point shift on the feedback product. Sits in the filter datapath where several single-channel exact first-order sections would otherwise be instantiated in parallel.

## Interface
- `W`, default 32: sample / state width, two's complement.
- `CW`, default 11: coefficient width, two's complement.
- `NCH`, default 4: channel count, ≥1.
- `FRAC`, default 0: arithmetic right shift applied to the product. 0 gives the exact integer section.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: sample offered.
- `in_ready`, out, 1: block accepts a sample this cycle.
- `in_ch`, in, CHW=max(1,$clog2(NCH)): channel of the offered sample.
- `x_in`, in, W: sample.
- `coef_we`, in, 1: coefficient write strobe.
- `coef_ch`, in, CHW: channel being written.
- `coef_data`, in, CW: new a1 for `coef_ch`.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer takes the result.
- `out_ch`, out, CHW: channel of the result.
- `y_out`, out, W: result.

## Operation
- Per channel c: `y = x + s[c]`; `s[c] <= trunc_W((y * a[c]) >>> FRAC) - x`. All adds wrap modulo 2^W, with no saturation. The product is the full signed W+CW-bit value before the shift.
- FSM states:
  - IDLE: `in_ready = !out_valid`. An accept (`in_valid && in_ready`) does the following at that edge:
    - registers `y_out` and `out_ch`, and sets `out_valid`;
    - latches x, channel and a[ch] into the working registers;
    - clears the Booth accumulator and moves to MUL.
  - MUL: runs one radix-4 Booth digit per cycle, M = ceil((CW+1)/2) cycles (6 for CW=11). On the edge ending the last digit it writes `s[ch]` and returns to IDLE. `in_ready` is 0 throughout.
- Output register: `out_valid` clears on `out_valid && out_ready`. While `out_valid && !out_ready`, `y_out` and `out_ch` hold stable and no new sample is accepted.
- Coefficient writes:
  - Accepted in any state, and they take effect at the edge.
  - A sample in flight uses the a[ch] latched at accept. This also covers a write to the same channel on the accept edge, so the old value is used.
- `in_ch` and `coef_ch` values ≥ NCH are ignored: no accept, no write. `in_ready` is still shown.
- Reset takes priority over everything, including mid-MUL:
  - all s[c]=0, all a[c]=0;
  - FSM goes to IDLE;
  - `out_valid=0`, `y_out=0`, `out_ch=0`;
  - `in_ready` is 1 in the first cycle after reset deasserts.

## Timing
- Accept at edge E0. `y_out` is valid from E0+ (1-cycle latency). `s[ch]` is updated at edge E0+M.
- With `out_ready` held high, `in_ready` rises after E0+M, giving a throughput of 1 sample per M+1 cycles.
- A sample to a channel always sees that channel's state from all earlier accepted samples, because there is no overlap.
- Interleaved channels are fully independent. Order across channels is acceptance order.

## Structure
- Package `fos_pkg`: state enum {IDLE, MUL}, the `booth_digits(CW)` function, and the CHW computation.
- Sub-module `booth_r4_seq`, parametrised on W and CW:
  - inputs: start, multiplicand, multiplier;
  - outputs: a W+CW-bit product and done;
  - one digit per cycle.
- The top level holds the FSM, per-channel register arrays, the output register and the shift/subtract.

## Test plan
- Reset, then ch0 a=2, x=1,0,0,0 → y=1,1,2,4. out_ch=0 each time, and the accept-to-accept spacing is 7 cycles when out_ready=1.
- ch1 a=-3 (0x7FD), x=5,0,0 → y=5,-20,60. ch0 (a=2, x=1,0,0) interleaved with it gives ch0 y=1,1,2, unaffected.
- out_ready low for 10 cycles after the first result → y_out/out_ch stable, in_ready=0 throughout. The next accept happens the cycle after the handshake.
- Write ch0 a=5 during MUL of a ch0 sample with a=2 and x=1 → that sample's state update uses 2 (s=1). The next sample x=0 gives y=1, then s=5.
- Wrap: x=0x7FFFFFFF with s=1 → y=0x80000000. FRAC=8 instance, a=128, x=100, s=0 → y=100, s=-50.
- Assert reset mid-MUL → out_valid=0 next cycle. The following sample x=7, a=0 → y=7, showing state and coefficient were cleared.

Source files
------------

// File: rtl/fos_pkg.sv
// Shared types and elaboration-time helpers for the time-multiplexed first-order IIR section.
package fos_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Radix-4 Booth digits needed to cover a CW-bit signed multiplier plus its sign guard bit.
    function automatic int booth_digits(input int cw);
        return (cw + 2) / 2;
    endfunction

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/fos_tdm_iir_booth_r4_seq.sv
// Iterative radix-4 Booth multiplier: one digit per cycle, full-width signed product.
module booth_r4_seq
    import fos_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 11,
    localparam int PW = W + CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  multiplicand,
    input  logic [CW-1:0] multiplier,
    output logic [PW-1:0] product,
    output logic          done
);

    localparam int M    = booth_digits(CW);
    localparam int MB   = 2 * M;
    localparam int CNTW = (M > 1) ? $clog2(M) : 1;

    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_mcand;
    logic [MB:0]     r_mplier;
    logic [CNTW-1:0] r_cnt;
    logic            r_busy;
    logic [PW-1:0]   w_pp;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_pp = '0;
        case (r_mplier[2:0])
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = r_mcand << 1;
            3'b100:         w_pp = -(r_mcand << 1);
            3'b101, 3'b110: w_pp = -r_mcand;
            default:        w_pp = '0;
        endcase
    end

    // The last digit's sum is presented combinationally so the caller can commit it on the same edge.
    assign product = r_acc + w_pp;
    assign done    = r_busy && (r_cnt == CNTW'(M - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CNTW'(1);
            if (done) r_busy <= 1'b0;
        end
    end

    // NOTE: operand/accumulator registers need no reset; start always reloads them before use.
    always_ff @(posedge clk) begin
        if (start) begin
            r_acc    <= '0;
            r_mcand  <= {{CW{multiplicand[W-1]}}, multiplicand};
            r_mplier <= {{(MB - CW){multiplier[CW-1]}}, multiplier, 1'b0};
        end else if (r_busy) begin
            r_acc    <= product;
            r_mcand  <= r_mcand << 2;
            r_mplier <= r_mplier >> 2;
        end
    end

endmodule

// File: rtl/fos_tdm_iir.sv
// Transposed-form first-order IIR section shared by NCH channels through one sequential Booth multiplier.
module fos_tdm_iir
    import fos_pkg::*;
#(
    parameter int W    = 32,
    parameter int CW   = 11,
    parameter int NCH  = 4,
    parameter int FRAC = 0,
    localparam int CHW = ch_width(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [W-1:0]   x_in,
    input  logic           coef_we,
    input  logic [CHW-1:0] coef_ch,
    input  logic [CW-1:0]  coef_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [W-1:0]   y_out
);

    localparam int  PW         = W + CW;
    localparam bit  FULL_RANGE = (NCH == (1 << CHW));

    state_t         r_state;
    state_t         w_state_next;

    logic [W-1:0]   r_s [NCH];
    logic [CW-1:0]  r_a [NCH];
    logic [W-1:0]   r_x;
    logic [CHW-1:0] r_ch;
    logic           r_out_valid;
    logic [W-1:0]   r_y_out;
    logic [CHW-1:0] r_out_ch;

    logic           w_in_ch_ok;
    logic           w_coef_ch_ok;
    logic           w_accept;
    logic           w_done;
    logic           w_booth_done;
    logic [W-1:0]   w_y;
    logic [PW-1:0]  w_prod;
    logic [W-1:0]   w_s_next;

    assign w_in_ch_ok   = FULL_RANGE || (int'(in_ch) < NCH);
    assign w_coef_ch_ok = FULL_RANGE || (int'(coef_ch) < NCH);
    assign w_accept     = in_valid && in_ready && w_in_ch_ok;
    assign w_done       = w_booth_done && (r_state == MUL);

    assign w_y      = x_in + r_s[in_ch];
    assign w_s_next = W'($signed(w_prod) >>> FRAC) - r_x;

    booth_r4_seq #(
        .W  (W),
        .CW (CW)
    ) u_booth (
        .clk          (clk),
        .reset        (reset),
        .start        (w_accept),
        .multiplicand (w_y),
        .multiplier   (r_a[in_ch]),
        .product      (w_prod),
        .done         (w_booth_done)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = MUL;
            MUL:     if (w_done)   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == IDLE) && !r_out_valid;
    end

    // NOTE: the per-channel state and coefficient arrays are reset explicitly, so a reset really restarts every channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_s[c] <= '0;
                r_a[c] <= '0;
            end
            r_x         <= '0;
            r_ch        <= '0;
            r_out_valid <= 1'b0;
            r_y_out     <= '0;
            r_out_ch    <= '0;
        end else begin
            // The multiplier already holds the pre-write coefficient, so a write here never affects an in-flight sample.
            if (coef_we && w_coef_ch_ok) r_a[coef_ch] <= coef_data;
            if (w_done) r_s[r_ch] <= w_s_next;
            if (w_accept) begin
                r_x         <= x_in;
                r_ch        <= in_ch;
                r_out_valid <= 1'b1;
                r_y_out     <= w_y;
                r_out_ch    <= in_ch;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y_out     = r_y_out;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_fos_tdm_iir.sv
// Self-checking bench: directed scenarios plus randomized traffic against a per-channel arithmetic model.
module tb_fos_tdm_iir;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [1:0]       in_valid, in_ready, coef_we, out_valid, out_ready;
    logic [1:0][1:0]  in_ch, coef_ch, out_ch;
    logic [1:0][31:0] x_in, y_out;
    logic [1:0][10:0] coef_data;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Reference state: index 0 is the exact instance, index 1 the FRAC=8 instance.
    logic [10:0] m_a [2][4];
    logic [31:0] m_s [2][4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fos_tdm_iir #(.W(32), .CW(11), .NCH(4), .FRAC(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ch(in_ch[0]), .x_in(x_in[0]),
        .coef_we(coef_we[0]), .coef_ch(coef_ch[0]), .coef_data(coef_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ch(out_ch[0]), .y_out(y_out[0])
    );

    fos_tdm_iir #(.W(32), .CW(11), .NCH(3), .FRAC(8)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ch(in_ch[1]), .x_in(x_in[1]),
        .coef_we(coef_we[1]), .coef_ch(coef_ch[1]), .coef_data(coef_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ch(out_ch[1]), .y_out(y_out[1])
    );

    // y = x + s; s' = trunc32((y * a) >>> frac) - x, with plain wide integer arithmetic.
    function automatic logic [31:0] model_step(input int d, input int ch, input logic [31:0] x);
        logic [31:0]        y;
        logic signed [63:0] p;
        y = x + m_s[d][ch];
        p = $signed(y) * $signed(m_a[d][ch]);
        p = p >>> ((d == 0) ? 0 : 8);
        m_s[d][ch] = p[31:0] - x;
        return y;
    endfunction

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        in_valid = '0;
        coef_we  = '0;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                m_s[d][c] = '0;
                m_a[d][c] = '0;
            end
    endtask

    task automatic wcoef(input int d, input int ch, input logic [10:0] a);
        coef_we[d]   = 1'b1;
        coef_ch[d]   = 2'(ch);
        coef_data[d] = a;
        @(posedge clk); #1;
        coef_we[d] = 1'b0;
        if (ch < ((d == 0) ? 4 : 3)) m_a[d][ch] = a;
    endtask

    // Offers one sample, waits (bounded) for acceptance, optionally writes a coefficient on the accept edge.
    task automatic push(input int d, input int ch, input logic [31:0] x,
                        input bit cw_en, input logic [10:0] cw_data,
                        output logic [31:0] y_obs, output logic [1:0] ch_obs, output bit ov_obs,
                        output logic [31:0] y_exp, output int acc_cyc, output bit ok);
        in_valid[d] = 1'b1;
        in_ch[d]    = 2'(ch);
        x_in[d]     = x;
        ok = 1'b0; acc_cyc = 0; y_obs = '0; ch_obs = '0; ov_obs = 1'b0; y_exp = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready[d] === 1'b1) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (ok) begin
            if (cw_en) begin
                coef_we[d]   = 1'b1;
                coef_ch[d]   = 2'(ch);
                coef_data[d] = cw_data;
            end
            acc_cyc = cyc;
            y_exp   = model_step(d, ch, x);
            if (cw_en) m_a[d][ch] = cw_data;
            @(posedge clk); #1;
            y_obs  = y_out[d];
            ch_obs = out_ch[d];
            ov_obs = out_valid[d];
            coef_we[d] = 1'b0;
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, out_valid[d]); end
            checks++;
            if (y_out[d] !== 32'h0) begin errors++; $display("FAIL reset_y_out[%0d]: got %h expected 0", d, y_out[d]); end
            checks++;
            if (out_ch[d] !== 2'd0) begin errors++; $display("FAIL reset_out_ch[%0d]: got %0d expected 0", d, out_ch[d]); end
            checks++;
            if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, in_ready[d]); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] xs  [4] = '{32'd1, 32'd0, 32'd0, 32'd0};
        logic [31:0] exp [4] = '{32'd1, 32'd1, 32'd2, 32'd4};
        logic [31:0] y, ye; logic [1:0] c; bit ov, ok; int acc, prev;
        wcoef(0, 0, 11'd2);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            push(0, 0, xs[i], 1'b0, 11'd0, y, c, ov, ye, acc, ok);
            checks++;
            if (!ok || !ov || y !== exp[i] || c !== 2'd0) begin
                errors++;
                $display("FAIL basic[%0d]: y=%h ch=%0d valid=%0b accepted=%0b, expected y=%h ch=0", i, y, c, ov, ok, exp[i]);
            end
            if (i > 0) begin
                checks++;
                if (acc - prev !== 7) begin errors++; $display("FAIL basic_spacing[%0d]: got %0d cycles expected 7", i, acc - prev); end
            end
            prev = acc;
        end
    endtask

    task automatic test_interleave();
        int          chs [6] = '{1, 0, 1, 0, 1, 0};
        logic [31:0] xs  [6] = '{32'd5, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] exp [6] = '{32'd5, 32'd1, 32'hFFFF_FFEC, 32'd1, 32'd60, 32'd2};
        logic [31:0] y, ye; logic [1:0] c; bit ov, ok; int acc;
        do_reset(2);
        wcoef(0, 0, 11'd2);
        wcoef(0, 1, 11'h7FD);
        for (int i = 0; i < 6; i++) begin
            push(0, chs[i], xs[i], 1'b0, 11'd0, y, c, ov, ye, acc, ok);
            checks++;
            if (!ok || !ov || y !== exp[i] || c !== 2'(chs[i])) begin
                errors++;
                $display("FAIL interleave[%0d]: y=%h ch=%0d, expected y=%h ch=%0d", i, y, c, exp[i], chs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] y, ye, hold_y; logic [1:0] c, hold_c; bit ov, ok; int acc, hs;
        wcoef(0, 3, 11'd3);
        out_ready[0] = 1'b0;
        push(0, 3, 32'd9, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        checks++;
        if (!ok || !ov || y !== ye || c !== 2'd3) begin
            errors++; $display("FAIL bp_first: y=%h ch=%0d, expected y=%h ch=3", y, c, ye);
        end
        hold_y = y_out[0]; hold_c = out_ch[0];
        in_valid[0] = 1'b1; in_ch[0] = 2'd0; x_in[0] = 32'd4;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (y_out[0] !== hold_y || out_ch[0] !== hold_c || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: y=%h ch=%0d ready=%b valid=%b, expected y=%h ch=%0d ready=0 valid=1",
                         i, y_out[0], out_ch[0], in_ready[0], out_valid[0], hold_y, hold_c);
            end
        end
        out_ready[0] = 1'b1;
        hs = cyc;
        push(0, 0, 32'd4, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        checks++;
        if (!ok || acc !== hs + 1) begin errors++; $display("FAIL bp_resume: accept at %0d expected %0d", acc, hs + 1); end
        checks++;
        if (y !== ye || c !== 2'd0) begin errors++; $display("FAIL bp_next: y=%h ch=%0d, expected y=%h ch=0", y, c, ye); end
    endtask

    task automatic test_coef_mid_mul();
        logic [31:0] exp [5] = '{32'd1, 32'd1, 32'd5, 32'd25, 32'd225};
        logic [31:0] xs  [5] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] y, ye; logic [1:0] c; bit ov, ok; int acc;
        do_reset(2);
        wcoef(0, 0, 11'd2);
        for (int i = 0; i < 5; i++) begin
            push(0, 0, xs[i], (i == 2), 11'd9, y, c, ov, ye, acc, ok);
            if (i == 0) wcoef(0, 0, 11'd5);
            checks++;
            if (!ok || !ov || y !== exp[i]) begin
                errors++; $display("FAIL coef_mid_mul[%0d]: y=%h expected %h", i, y, exp[i]);
            end
        end
    endtask

    task automatic test_wrap_frac();
        logic [31:0] y, ye; logic [1:0] c; bit ov, ok; int acc;
        do_reset(2);
        push(0, 2, 32'hFFFF_FFFF, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        checks++;
        if (!ok || y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_prep: y=%h expected ffffffff", y); end
        push(0, 2, 32'h7FFF_FFFF, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        checks++;
        if (!ok || y !== 32'h8000_0000) begin errors++; $display("FAIL wrap: y=%h expected 80000000", y); end
        wcoef(1, 0, 11'd128);
        push(1, 0, 32'd100, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        checks++;
        if (!ok || y !== 32'd100) begin errors++; $display("FAIL frac_first: y=%h expected 00000064", y); end
        push(1, 0, 32'd0, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        checks++;
        if (!ok || y !== 32'hFFFF_FFCE) begin errors++; $display("FAIL frac_state: y=%h expected ffffffce", y); end
        repeat (8) @(posedge clk);
        #1;
        in_valid[1] = 1'b1; in_ch[1] = 2'd3; x_in[1] = 32'd5;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL bad_ch_ready[%0d]: got %b expected 1", i, in_ready[1]); end
            @(posedge clk); #1;
            checks++;
            if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL bad_ch_accept[%0d]: out_valid=%b expected 0", i, out_valid[1]); end
        end
        in_valid[1] = 1'b0;
        push(1, 0, 32'd0, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        checks++;
        if (!ok || y !== ye) begin errors++; $display("FAIL frac_after_bad_ch: y=%h expected %h", y, ye); end
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] y, ye; logic [1:0] c; bit ov, ok; int acc;
        wcoef(0, 0, 11'd3);
        out_ready[0] = 1'b0;
        push(0, 0, 32'd11, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                m_s[d][k] = '0;
                m_a[d][k] = '0;
            end
        checks++;
        if (out_valid[0] !== 1'b0 || y_out[0] !== 32'h0 || in_ready[0] !== 1'b1) begin
            errors++; $display("FAIL reset_mid_mul: valid=%b y=%h ready=%b expected 0/0/1", out_valid[0], y_out[0], in_ready[0]);
        end
        out_ready[0] = 1'b1;
        push(0, 0, 32'd7, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        checks++;
        if (!ok || y !== 32'd7) begin errors++; $display("FAIL post_reset_y: y=%h expected 00000007", y); end
        push(0, 0, 32'd0, 1'b0, 11'd0, y, c, ov, ye, acc, ok);
        checks++;
        if (!ok || y !== 32'hFFFF_FFF9) begin errors++; $display("FAIL post_reset_state: y=%h expected fffffff9", y); end
    endtask

    task automatic test_random();
        logic [31:0] y, ye, x; logic [1:0] c; bit ov, ok; int acc, d, ch;
        for (int i = 0; i < 80; i++) begin
            d  = $urandom_range(0, 1);
            ch = $urandom_range(0, (d == 0) ? 3 : 2);
            if ($urandom_range(0, 3) == 0) wcoef(d, ch, 11'($urandom));
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 400)) - 32'd200;
            push(d, ch, x, ($urandom_range(0, 7) == 0), 11'($urandom), y, c, ov, ye, acc, ok);
            checks++;
            if (!ok || !ov || y !== ye || c !== 2'(ch)) begin
                errors++;
                $display("FAIL random[%0d] dut%0d: y=%h ch=%0d valid=%0b, expected y=%h ch=%0d", i, d, y, c, ov, ye, ch);
            end
        end
    endtask

    initial begin
        in_valid = '0; coef_we = '0; out_ready = '1;
        in_ch = '0; coef_ch = '0; x_in = '0; coef_data = '0;
        test_reset();
        test_basic();
        test_interleave();
        test_backpressure();
        test_coef_mid_mul();
        test_wrap_frac();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached after %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
